serial_frame_receiver: RTL

- Upstream control stage for the 1-to-4 serial port demultiplexer.
- Watches a single serial line for a frame (start bit, 2-bit port number, 4-bit data length, payload bits) and decodes the header.
- Drives the demux `portnum` select and a gated serial output so that only payload bits reach the selected port.
- Pulses `done` at end of frame.

---
 rtl/serial_frame_pkg.sv | 22 ++
 rtl/bit_down_counter.sv | 37 +++
 rtl/serial_frame_receiver.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/serial_frame_pkg.sv
// Shared constants for the serial frame receiver: header field widths, start-bit level,
// FSM state encodings and a small helper for sizing the header bit-index counter.
package serial_frame_pkg;

  localparam int   PORT_W_DEF = 2;
  localparam int   LEN_W_DEF  = 4;
  localparam logic START_BIT  = 1'b0;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PORT   = 3'd1;
  localparam logic [2:0] S_LEN    = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_down_counter.sv
// Loadable saturating down-counter with zero flag; used for the header bit index
// and for the remaining-payload count.
module bit_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame header decoder driving the 1-to-4 demux select and gated payload output.
// Optional even-parity check after the payload is enabled by SERIAL_FRAME_PARITY_EN.
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit
// PORT   | shifting in the port-number field
// LEN    | shifting in the payload length field
// DATA   | payload bit on SerOut, data_left counting down
// PARITY | sampling the even-parity bit (optional build)
// DONE   | one-cycle done pulse, SerIn ignored
module serial_frame_receiver
  import serial_frame_pkg::*;
#(
  parameter int PORT_W = PORT_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SerIn,
  output logic [PORT_W-1:0] portnum,
  output logic              SerOut,
  output logic              SerOutValid,
  output logic [LEN_W-1:0]  data_left,
  output logic              done,
  output logic              parity_err
);

  localparam int IDX_W = $clog2(max_int(PORT_W, LEN_W) + 1);

`ifdef SERIAL_FRAME_PARITY_EN
  localparam logic [2:0] S_AFTER_PAY = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_PAY = S_DONE;
`endif

  logic [2:0]        state_q, state_d;
  logic [PORT_W-1:0] portnum_q, portnum_d;

  logic              idx_load, idx_dec, idx_zero;
  logic [IDX_W-1:0]  idx_load_val, idx_count;

  logic              len_load, len_dec, len_zero;
  logic [LEN_W-1:0]  len_load_val, len_count;

  logic              start_det;
  logic              unused_cnt;

  assign start_det  = (state_q == S_IDLE) && (SerIn == START_BIT);
  assign unused_cnt = ^{idx_count, len_zero};

  always_comb begin
    state_d      = state_q;
    portnum_d    = portnum_q;
    idx_load     = 1'b0;
    idx_load_val = '0;
    idx_dec      = 1'b0;
    len_load     = 1'b0;
    len_load_val = len_count;
    len_dec      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_det) begin
          state_d      = S_PORT;
          idx_load     = 1'b1;
          idx_load_val = IDX_W'(PORT_W - 1);
        end
      end
      S_PORT: begin
        portnum_d = {portnum_q[PORT_W-2:0], SerIn};
        if (idx_zero) begin
          state_d      = S_LEN;
          idx_load     = 1'b1;
          idx_load_val = IDX_W'(LEN_W - 1);
        end else begin
          idx_dec = 1'b1;
        end
      end
      S_LEN: begin
        // The length field is assembled directly in the payload counter.
        len_load     = 1'b1;
        len_load_val = {len_count[LEN_W-2:0], SerIn};
        if (idx_zero) begin
          state_d = (len_load_val != '0) ? S_DATA : S_AFTER_PAY;
        end else begin
          idx_dec = 1'b1;
        end
      end
      S_DATA: begin
        len_dec = 1'b1;
        if (len_count == LEN_W'(1)) begin
          state_d = S_AFTER_PAY;
        end
      end
`ifdef SERIAL_FRAME_PARITY_EN
      S_PARITY: begin
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      portnum_q <= '0;
    end else begin
      state_q   <= state_d;
      portnum_q <= portnum_d;
    end
  end

  bit_down_counter #(.W(IDX_W)) u_idx_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (idx_load),
    .load_val_i (idx_load_val),
    .dec_i      (idx_dec),
    .count_o    (idx_count),
    .zero_o     (idx_zero)
  );

  bit_down_counter #(.W(LEN_W)) u_len_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (len_load),
    .load_val_i (len_load_val),
    .dec_i      (len_dec),
    .count_o    (len_count),
    .zero_o     (len_zero)
  );

`ifdef SERIAL_FRAME_PARITY_EN
  logic pxor_q, pxor_d;
  logic perr_q, perr_d;

  always_comb begin
    pxor_d = pxor_q;
    perr_d = perr_q;
    if (start_det) begin
      pxor_d = 1'b0;
      perr_d = 1'b0;
    end else if (state_q == S_DATA) begin
      pxor_d = pxor_q ^ SerIn;
    end else if (state_q == S_PARITY) begin
      perr_d = pxor_q ^ SerIn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pxor_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      pxor_q <= pxor_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign portnum     = portnum_q;
  assign data_left   = len_count;
  assign SerOutValid = (state_q == S_DATA);
  assign SerOut      = SerIn & SerOutValid;
  assign done        = (state_q == S_DONE);

endmodule
